wb_arbiter: RTL and testbench

- Write-back arbiter feeding the register file's single write port (we/waddr/wdata).
- Merges two sources:
  - Port A: in-order pipeline write-back (MEM/WB). Highest priority, never stalled.
  - Port B: long-latency unit (divider / miss load). Valid/ready handshake, buffered in a small FIFO.
- Also gives ID per-read-port pending flags and a starvation stall request.

---
 rtl/wb_arbiter.sv | 144 ++++++++++++++
 tb/tb_wb_arbiter.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// Write-back arbiter: merges the in-order pipeline write port (A) with a buffered long-latency port (B).
// Optional WB_BYPASS_EN: a B write that finds the FIFO empty and A idle goes straight to the output register.
module wb_arbiter #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 5,
    parameter int DEPTH      = 4,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_waddr,
    input  logic [DATA_W-1:0] a_wdata,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic [ADDR_W-1:0] b_waddr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              we,
    output logic [ADDR_W-1:0] waddr,
    output logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr1,
    input  logic [ADDR_W-1:0] raddr2,
    output logic              pend1,
    output logic              pend2,
    output logic              stall_req
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam int STV_W = $clog2(STARVE_MAX + 1);

    logic [ADDR_W-1:0] fifo_addr [DEPTH];
    logic [DATA_W-1:0] fifo_data [DEPTH];
    logic [DEPTH-1:0]  fifo_valid;
    logic [DEPTH-1:0]  fifo_kill;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [STV_W-1:0]  starve_cnt;

    logic a_busy;
    logic fifo_empty;
    logic b_fire;
    logic b_live;
    logic bypass;
    logic push;
    logic pop;
    logic starve_cond;

    // Writes to r0 are no-ops, so an A write to r0 leaves the port free for the FIFO.
    assign a_busy      = a_we && (a_waddr != '0);
    assign fifo_empty  = (count == '0);
    assign b_ready     = !rst && (count < CNT_W'(DEPTH));
    assign b_fire      = b_valid && b_ready;
    assign b_live      = b_fire && (b_waddr != '0);
    assign pop         = !a_busy && !fifo_empty;
    assign starve_cond = !fifo_empty && a_busy;

`ifdef WB_BYPASS_EN
    assign bypass = b_live && fifo_empty && !a_busy;
`else
    assign bypass = 1'b0;
`endif

    assign push = b_live && !bypass;

    always_comb begin
        pend1 = 1'b0;
        pend2 = 1'b0;
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (fifo_valid[i] && !fifo_kill[i]) begin
                    if ((raddr1 != '0) && (fifo_addr[i] == raddr1)) pend1 = 1'b1;
                    if ((raddr2 != '0) && (fifo_addr[i] == raddr2)) pend2 = 1'b1;
                end
            end
        end
    end

    // A newer A write to the same register makes a queued B write stale; it still drains, but silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            fifo_valid <= '0;
            fifo_kill  <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (a_busy && fifo_valid[i] && (fifo_addr[i] == a_waddr)) fifo_kill[i] <= 1'b1;
            end
            if (pop) begin
                fifo_valid[rd_ptr] <= 1'b0;
                rd_ptr             <= rd_ptr + PTR_W'(1);
            end
            if (push) begin
                fifo_valid[wr_ptr] <= 1'b1;
                fifo_kill[wr_ptr]  <= a_busy && (a_waddr == b_waddr);
                fifo_addr[wr_ptr]  <= b_waddr;
                fifo_data[wr_ptr]  <= b_wdata;
                wr_ptr             <= wr_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(push) - CNT_W'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            we    <= 1'b0;
            waddr <= '0;
            wdata <= '0;
        end else if (a_busy) begin
            we    <= 1'b1;
            waddr <= a_waddr;
            wdata <= a_wdata;
        end else if (pop) begin
            we    <= !fifo_kill[rd_ptr];
            waddr <= fifo_addr[rd_ptr];
            wdata <= fifo_data[rd_ptr];
        end else if (bypass) begin
            we    <= 1'b1;
            waddr <= b_waddr;
            wdata <= b_wdata;
        end else begin
            we <= 1'b0;
        end
    end

    // stall_req looks one cycle ahead so it drops in the cycle right after the FIFO finally gets a slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_req  <= 1'b0;
        end else begin
            if (!starve_cond) begin
                starve_cnt <= '0;
            end else if (starve_cnt < STV_W'(STARVE_MAX)) begin
                starve_cnt <= starve_cnt + STV_W'(1);
            end
            stall_req <= starve_cond && (starve_cnt >= STV_W'(STARVE_MAX - 1));
        end
    end

endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: a queue-based reference model feeds a per-cycle scoreboard,
// and scenario tasks check pend flags, handshake, starvation and exact latencies inline.
module tb_wb_arbiter;

    localparam int DATA_W     = 32;
    localparam int ADDR_W     = 5;
    localparam int DEPTH      = 4;
    localparam int STARVE_MAX = 8;
`ifdef WB_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic              a_we;
    logic [ADDR_W-1:0] a_waddr;
    logic [DATA_W-1:0] a_wdata;
    logic              b_valid;
    logic              b_ready;
    logic [ADDR_W-1:0] b_waddr;
    logic [DATA_W-1:0] b_wdata;
    logic              we;
    logic [ADDR_W-1:0] waddr;
    logic [DATA_W-1:0] wdata;
    logic [ADDR_W-1:0] raddr1;
    logic [ADDR_W-1:0] raddr2;
    logic              pend1;
    logic              pend2;
    logic              stall_req;

    wb_arbiter #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk), .rst(rst),
        .a_we(a_we), .a_waddr(a_waddr), .a_wdata(a_wdata),
        .b_valid(b_valid), .b_ready(b_ready), .b_waddr(b_waddr), .b_wdata(b_wdata),
        .we(we), .waddr(waddr), .wdata(wdata),
        .raddr1(raddr1), .raddr2(raddr2), .pend1(pend1), .pend2(pend2),
        .stall_req(stall_req)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              we;
        logic              chk;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic              kill;
    } ent_t;

    exp_t        exp_q[$];
    ent_t        model_q[$];
    logic [DATA_W-1:0] rf [32];
    int compared   = 0;
    int mismatched = 0;

    // Reference model: consumes the inputs at each rising edge and queues the expected output register.
    always @(posedge clk) begin : model
        exp_t e;
        ent_t h;
        ent_t n;
        logic abusy;
        logic bfire;
        logic byp;
        abusy = a_we && (a_waddr != '0);
        bfire = b_valid && (model_q.size() < DEPTH);
        byp   = 1'b0;
        e     = '{1'b0, 1'b0, '0, '0};
        if (rst) begin
            model_q.delete();
            e.chk = 1'b1;
        end else begin
            foreach (model_q[i]) if (abusy && model_q[i].addr == a_waddr) model_q[i].kill = 1'b1;
            byp = BYPASS && bfire && (b_waddr != '0) && (model_q.size() == 0) && !abusy;
            if (abusy) begin
                e = '{1'b1, 1'b1, a_waddr, a_wdata};
            end else if (model_q.size() > 0) begin
                h = model_q.pop_front();
                e = '{!h.kill, 1'b1, h.addr, h.data};
            end else if (byp) begin
                e = '{1'b1, 1'b1, b_waddr, b_wdata};
            end
            if (bfire && (b_waddr != '0) && !byp) begin
                n = '{b_waddr, b_wdata, abusy && (a_waddr == b_waddr)};
                model_q.push_back(n);
            end
        end
        exp_q.push_back(e);
    end

    always @(negedge clk) begin : scoreboard
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            compared++;
            if (we !== e.we || (e.chk && (waddr !== e.addr || wdata !== e.data))) begin
                mismatched++;
                $display("[TB] FAIL scoreboard: got we=%0b waddr=%0d wdata=%h, expected we=%0b waddr=%0d wdata=%h (fields checked=%0b)",
                         we, waddr, wdata, e.we, e.addr, e.data, e.chk);
            end
            if (we === 1'b1) rf[waddr] = wdata;
        end
    end

    task automatic set_idle();
        a_we = 1'b0; a_waddr = '0; a_wdata = '0;
        b_valid = 1'b0; b_waddr = '0; b_wdata = '0;
    endtask

    task automatic test_reset();
        rst = 1'b1; set_idle(); raddr1 = 5'd7; raddr2 = 5'd7;
        repeat (2) @(negedge clk);
        compared++;
        if (b_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_b_ready: got %0b, expected 0", b_ready); end
        compared++;
        if ({we, stall_req, pend1, pend2} !== 4'b0000) begin
            mismatched++; $display("[TB] FAIL reset_flags: got we/stall/p1/p2=%b, expected 0000", {we, stall_req, pend1, pend2});
        end
        compared++;
        if (waddr !== '0 || wdata !== '0) begin
            mismatched++; $display("[TB] FAIL reset_fields: got waddr=%0d wdata=%h, expected 0/0", waddr, wdata);
        end
        rst = 1'b0;
        @(negedge clk);
        compared++;
        if (b_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL post_reset_ready: got %0b, expected 1", b_ready); end
    endtask

    task automatic test_a_stream();
        logic [ADDR_W-1:0] last;
        a_we = 1'b1; a_waddr = 5'd3; a_wdata = 32'h11;
        @(negedge clk);
        compared++;
        if (we !== 1'b1 || waddr !== 5'd3 || wdata !== 32'h11) begin
            mismatched++; $display("[TB] FAIL a_latency: got %0b/%0d/%h, expected 1/3/00000011", we, waddr, wdata);
        end
        for (int i = 0; i < 3; i++) begin
            a_waddr = ADDR_W'($urandom_range(1, 31)); a_wdata = $urandom;
            @(negedge clk);
        end
        last = a_waddr;
        a_waddr = '0; a_wdata = 32'h55;
        @(negedge clk);
        compared++;
        if (we !== 1'b0 || waddr !== last) begin
            mismatched++; $display("[TB] FAIL a_r0_idle: got we=%0b waddr=%0d, expected 0/%0d", we, waddr, last);
        end
        set_idle();
        @(negedge clk);
    endtask

    task automatic test_b_single();
        raddr1 = 5'd7; raddr2 = 5'd0;
        b_valid = 1'b1; b_waddr = 5'd7; b_wdata = 32'hDEAD;
        #1;
        compared++;
        if (b_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b_single_ready: got %0b, expected 1", b_ready); end
        @(negedge clk);
        set_idle();
        #1;
        compared++;
        if (pend1 !== !BYPASS || pend2 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL b_single_pend: got p1=%0b p2=%0b, expected %0b/0", pend1, pend2, !BYPASS);
        end
        compared++;
        if (we !== BYPASS) begin mismatched++; $display("[TB] FAIL b_single_early: got we=%0b, expected %0b", we, BYPASS); end
        @(negedge clk);
        compared++;
        if (pend1 !== 1'b0 || we !== !BYPASS || (!BYPASS && (waddr !== 5'd7 || wdata !== 32'hDEAD))) begin
            mismatched++; $display("[TB] FAIL b_single_write: got p1=%0b we=%0b waddr=%0d wdata=%h, expected 0/%0b/7/0000dead",
                                   pend1, we, waddr, wdata, !BYPASS);
        end
        b_valid = 1'b1; b_waddr = '0; b_wdata = 32'hBAD;
        #1;
        compared++;
        if (b_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL b_r0_ready: got %0b, expected 1", b_ready); end
        @(negedge clk);
        set_idle();
        for (int i = 0; i < 2; i++) begin
            compared++;
            if (we !== 1'b0) begin mismatched++; $display("[TB] FAIL b_r0_dropped: cycle %0d got we=%0b, expected 0", i, we); end
            @(negedge clk);
        end
    endtask

    task automatic test_fill_drain();
        raddr1 = 5'd12; raddr2 = 5'd15;
        for (int i = 0; i < DEPTH; i++) begin
            a_we = 1'b1; a_waddr = ADDR_W'(20 + i); a_wdata = $urandom;
            b_valid = 1'b1; b_waddr = ADDR_W'(12 + i); b_wdata = 32'hB000 + i;
            #1;
            compared++;
            if (b_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL fill_ready: entry %0d got %0b, expected 1", i, b_ready); end
            @(negedge clk);
        end
        a_waddr = 5'd24; a_wdata = $urandom; b_waddr = 5'd16; b_wdata = 32'hFFFF;
        #1;
        compared++;
        if (b_ready !== 1'b0) begin mismatched++; $display("[TB] FAIL full_ready: got %0b, expected 0", b_ready); end
        compared++;
        if (pend1 !== 1'b1 || pend2 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL full_pend: got p1=%0b p2=%0b, expected 1/1", pend1, pend2);
        end
        @(negedge clk);
        set_idle();
        for (int i = 0; i < DEPTH; i++) begin
            @(negedge clk);
            compared++;
            if (we !== 1'b1 || waddr !== ADDR_W'(12 + i) || wdata !== 32'hB000 + i) begin
                mismatched++; $display("[TB] FAIL drain_order: slot %0d got %0b/%0d/%h, expected 1/%0d/%h",
                                       i, we, waddr, wdata, 12 + i, 32'hB000 + i);
            end
            if (i == 0) begin
                compared++;
                if (b_ready !== 1'b1) begin mismatched++; $display("[TB] FAIL drain_ready: got %0b, expected 1", b_ready); end
            end
        end
        #1;
        compared++;
        if (pend1 !== 1'b0 || pend2 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL drained_pend: got p1=%0b p2=%0b, expected 0/0", pend1, pend2);
        end
    endtask

    task automatic test_waw_kill();
        raddr1 = 5'd5; raddr2 = 5'd6;
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = 32'h99;
        b_valid = 1'b1; b_waddr = 5'd5; b_wdata = 32'hAAAA;
        @(negedge clk);
        b_valid = 1'b0; a_waddr = 5'd5; a_wdata = 32'hBBBB;
        #1;
        compared++;
        if (pend1 !== 1'b1) begin mismatched++; $display("[TB] FAIL kill_pend_before: got %0b, expected 1", pend1); end
        @(negedge clk);
        compared++;
        if (pend1 !== 1'b0) begin mismatched++; $display("[TB] FAIL kill_pend_after: got %0b, expected 0", pend1); end
        set_idle();
        @(negedge clk);
        compared++;
        if (we !== 1'b0 || waddr !== 5'd5 || wdata !== 32'hAAAA) begin
            mismatched++; $display("[TB] FAIL killed_pop: got %0b/%0d/%h, expected 0/5/0000aaaa", we, waddr, wdata);
        end
        #1;
        compared++;
        if (rf[5] !== 32'hBBBB) begin mismatched++; $display("[TB] FAIL waw_final_r5: got %h, expected 0000bbbb", rf[5]); end
        a_we = 1'b1; a_waddr = 5'd6; a_wdata = 32'h66;
        b_valid = 1'b1; b_waddr = 5'd6; b_wdata = 32'h77;
        @(negedge clk);
        set_idle();
        #1;
        compared++;
        if (pend2 !== 1'b0) begin mismatched++; $display("[TB] FAIL same_cycle_kill_pend: got %0b, expected 0", pend2); end
        @(negedge clk);
        compared++;
        if (we !== 1'b0 || wdata !== 32'h77) begin
            mismatched++; $display("[TB] FAIL same_cycle_kill_pop: got we=%0b wdata=%h, expected 0/00000077", we, wdata);
        end
    endtask

    task automatic test_starvation();
        a_we = 1'b1; a_waddr = 5'd9; a_wdata = $urandom;
        b_valid = 1'b1; b_waddr = 5'd10; b_wdata = 32'hC0DE;
        @(negedge clk);
        b_valid = 1'b0; b_waddr = '0;
        for (int k = 1; k <= 10; k++) begin
            compared++;
            if (stall_req !== (k >= STARVE_MAX + 1)) begin
                mismatched++; $display("[TB] FAIL stall_rise: cycle %0d got %0b, expected %0b", k, stall_req, k >= STARVE_MAX + 1);
            end
            if (k == 10) set_idle();
            else a_wdata = $urandom;
            @(negedge clk);
        end
        compared++;
        if (stall_req !== 1'b0 || we !== 1'b1 || waddr !== 5'd10 || wdata !== 32'hC0DE) begin
            mismatched++; $display("[TB] FAIL stall_release: got stall=%0b %0b/%0d/%h, expected 0 1/10/0000c0de",
                                   stall_req, we, waddr, wdata);
        end
    endtask

    task automatic test_reset_mid();
        raddr1 = 5'd13; raddr2 = 5'd15;
        for (int i = 0; i < DEPTH; i++) begin
            a_we = 1'b1; a_waddr = ADDR_W'(20 + i); a_wdata = $urandom;
            b_valid = 1'b1; b_waddr = ADDR_W'(12 + i); b_wdata = 32'hE0 + i;
            @(negedge clk);
        end
        set_idle();
        @(negedge clk);
        #1;
        compared++;
        if (pend1 !== 1'b1 || pend2 !== 1'b1) begin
            mismatched++; $display("[TB] FAIL mid_pend_queued: got p1=%0b p2=%0b, expected 1/1", pend1, pend2);
        end
        rst = 1'b1;
        #1;
        compared++;
        if (b_ready !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0) begin
            mismatched++; $display("[TB] FAIL mid_rst_comb: got ready=%0b p1=%0b p2=%0b, expected 0/0/0", b_ready, pend1, pend2);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            compared++;
            if (we !== 1'b0 || pend1 !== 1'b0 || pend2 !== 1'b0 || b_ready !== 1'b1) begin
                mismatched++; $display("[TB] FAIL mid_rst_discard: cycle %0d got we=%0b p1=%0b p2=%0b ready=%0b, expected 0/0/0/1",
                                       i, we, pend1, pend2, b_ready);
            end
            @(negedge clk);
        end
    endtask

    initial begin
        test_reset();
        test_a_stream();
        test_b_single();
        test_fill_drain();
        test_waw_kill();
        test_starvation();
        test_reset_mid();
        set_idle();
        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
